// File: rtl/arb_pkg.sv
// arb_pkg: shared state type and one-hot helpers for the grant-hold stage.
package arb_pkg;
    typedef enum logic {IDLE, HOLD} state_t;
    localparam int MAX_N = 64;
    localparam int DEF_N = 8;
    localparam int DEF_IDX_W = $clog2(DEF_N);
    function automatic logic is_onehot0(logic [MAX_N-1:0] v);
        return (v & (v - MAX_N'(1))) == '0;
    endfunction
    // v holds an [0:n-1] vector zero-extended, so index i sits at bit n-1-i
    function automatic int onehot_idx(logic [MAX_N-1:0] v, int n);
        int idx = 0;
        for (int i = 0; i < MAX_N; i++)
            if (i < n && v[n-1-i]) idx |= i;
        return idx;
    endfunction
endpackage

// File: rtl/arb_onehot_enc.sv
// arb_onehot_enc: one-hot to index encoder, bit 0 leftmost; zero input gives 0.
module arb_onehot_enc
    import arb_pkg::*;
#(
    parameter int N = DEF_N,
    parameter int W = $clog2(N)
) (
    input  logic [0:N-1]  vec,
    output logic [W-1:0]  idx
);
    assign idx = W'(onehot_idx(MAX_N'(vec), N));
endmodule

// File: rtl/arbiter_grant_hold.sv
// arbiter_grant_hold: registers the arbiter grant, holds it while the owner requests,
// force-releases after MAXHOLD cycles and masks that owner for one round.
module arbiter_grant_hold
    import arb_pkg::*;
#(
    parameter int N = 8,
    parameter int MAXHOLD = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [0:N-1]         r,
    output logic [0:N-1]         r_arb,
    input  logic [0:N-1]         g_arb,
    output logic [0:N-1]         gnt,
    output logic                 gnt_valid,
    output logic [$clog2(N)-1:0] gnt_idx,
    output logic                 expired,
    output logic                 err
);
    localparam int IW = $clog2(N);
    localparam int CW = $clog2(MAXHOLD + 1);
    state_t         state, state_n;
    logic [0:N-1]   mask, mask_n, gnt_n;
    logic [CW-1:0]  cnt, cnt_n;
    logic [IW-1:0]  idx_enc, idx_n;
    logic           expired_n, err_n, legal;
    assign r_arb = r & ~mask;
    assign gnt_valid = |gnt;
    assign legal = is_onehot0(MAX_N'(g_arb)) && ((g_arb & ~r_arb) == '0);
    arb_onehot_enc #(.N(N), .W(IW)) u_enc (.vec(g_arb), .idx(idx_enc));
    always_comb begin
        state_n = state;
        gnt_n = gnt;
        idx_n = gnt_idx;
        cnt_n = cnt;
        mask_n = mask;
        expired_n = 1'b0;
        err_n = err;
        if (state == IDLE) begin
            if (r_arb == '0) mask_n = '0;
            if (!legal) err_n = 1'b1;
            else if (|g_arb) begin
                gnt_n = g_arb;
                idx_n = idx_enc;
                cnt_n = CW'(1);
                mask_n = '0;
                state_n = HOLD;
            end
        end else if (!(|(r & gnt))) begin
            gnt_n = '0;
            idx_n = '0;
            cnt_n = '0;
            state_n = IDLE;
        end else if (cnt < CW'(MAXHOLD)) begin
            cnt_n = cnt + CW'(1);
        end else begin
            // burst limit reached: hide this owner until the next round
            gnt_n = '0;
            idx_n = '0;
            cnt_n = '0;
            mask_n = gnt;
            expired_n = 1'b1;
            state_n = IDLE;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            gnt <= '0;
            gnt_idx <= '0;
            cnt <= '0;
            mask <= '0;
            expired <= 1'b0;
            err <= 1'b0;
        end else begin
            state <= state_n;
            gnt <= gnt_n;
            gnt_idx <= idx_n;
            cnt <= cnt_n;
            mask <= mask_n;
            expired <= expired_n;
            err <= err_n;
        end
    end
endmodule

// File: tb/tb_arbiter_grant_hold.sv
// tb_arbiter_grant_hold: directed plan plus random traffic against an index-level model,
// with a fixed-priority arbiter closing the r_arb -> g_arb loop.
module tb_arbiter_grant_hold;
    localparam int N = 8;
    localparam int MH = 4;
    localparam int IW = $clog2(N);
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [0:N-1] r = '0;
    logic [0:N-1] g_force = '0;
    logic force_g = 1'b0;
    logic [0:N-1] r_arb, g_arb, gnt;
    logic gnt_valid, expired, err;
    logic [IW-1:0] gnt_idx;
    int n_vec = 0;
    int n_bad = 0;
    int owner = -1;
    int run = 0;
    int masked = -1;
    bit m_err = 1'b0;
    bit m_exp = 1'b0;

    always #5 clk = ~clk;

    function automatic logic [0:N-1] bitv(int i);
        logic [0:N-1] v = '0;
        if (i >= 0) v[i] = 1'b1;
        return v;
    endfunction

    function automatic int first(logic [0:N-1] v);
        for (int i = 0; i < N; i++)
            if (v[i]) return i;
        return -1;
    endfunction

    assign g_arb = force_g ? g_force : bitv(first(r_arb));

    arbiter_grant_hold #(.N(N), .MAXHOLD(MH)) dut (
        .clk(clk), .rst(rst), .r(r), .r_arb(r_arb), .g_arb(g_arb),
        .gnt(gnt), .gnt_valid(gnt_valid), .gnt_idx(gnt_idx),
        .expired(expired), .err(err)
    );

    function automatic logic [0:N-1] exp_rarb();
        return r & ~bitv(masked);
    endfunction

    task automatic chk(string tag, logic [31:0] got, logic [31:0] want);
        n_vec++;
        assert (got === want) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic check_all();
        chk("gnt", 32'(gnt), 32'(bitv(owner)));
        chk("gnt_valid", 32'(gnt_valid), 32'(owner >= 0));
        chk("gnt_idx", 32'(gnt_idx), owner >= 0 ? 32'(owner) : 32'd0);
        chk("expired", 32'(expired), 32'(m_exp));
        chk("err", 32'(err), 32'(m_err));
        chk("r_arb", 32'(r_arb), 32'(exp_rarb()));
    endtask

    // one clock: model advances on the edge from the bench's own view of the inputs
    task automatic tick();
        logic [0:N-1] ra, g;
        @(posedge clk);
        ra = exp_rarb();
        g = force_g ? g_force : bitv(first(ra));
        if (rst) begin
            owner = -1; run = 0; masked = -1; m_err = 1'b0; m_exp = 1'b0;
        end else if (owner < 0) begin
            m_exp = 1'b0;
            if (ra == '0) masked = -1;
            if ($countones(g) > 1 || (g & ~ra) != '0) m_err = 1'b1;
            else if (g != '0) begin
                owner = first(g); run = 1; masked = -1;
            end
        end else if (!r[owner]) begin
            owner = -1; m_exp = 1'b0;
        end else if (run < MH) begin
            run++; m_exp = 1'b0;
        end else begin
            masked = owner; owner = -1; m_exp = 1'b1;
        end
        @(negedge clk);
        check_all();
    endtask

    initial begin
        tick();
        tick();
        rst = 1'b0;
        // reset while holding
        r = 8'b0100_0000;
        tick();
        tick();
        chk("hold_gnt", 32'(gnt), 32'(8'b0100_0000));
        rst = 1'b1;
        tick();
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_idx", 32'(gnt_idx), 32'd0);
        rst = 1'b0;
        r = '0;
        tick();
        // basic grant and release
        r = 8'b0011_0000;
        tick();
        chk("basic_gnt", 32'(gnt), 32'(8'b0010_0000));
        chk("basic_idx", 32'(gnt_idx), 32'd2);
        tick();
        tick();
        r = 8'b0001_0000;
        tick();
        chk("basic_gap", 32'(gnt), 32'd0);
        tick();
        chk("basic_next", 32'(gnt), 32'(8'b0001_0000));
        r = '0;
        tick();
        tick();
        // forced release and fairness
        r = 8'b1000_0001;
        for (int i = 0; i < MH; i++) begin
            tick();
            chk("burst_gnt", 32'(gnt), 32'(8'b1000_0000));
        end
        tick();
        chk("force_gnt", 32'(gnt), 32'd0);
        chk("force_exp", 32'(expired), 32'd1);
        chk("force_rarb", 32'(r_arb), 32'(8'b0000_0001));
        tick();
        chk("fair_gnt", 32'(gnt), 32'(8'b0000_0001));
        chk("fair_exp", 32'(expired), 32'd0);
        r = '0;
        tick();
        tick();
        // mask clears when nobody else asks
        r = 8'b1000_0000;
        for (int i = 0; i < MH; i++) tick();
        tick();
        chk("solo_rarb0", 32'(r_arb), 32'd0);
        tick();
        chk("solo_idle", 32'(gnt), 32'd0);
        chk("solo_rarb", 32'(r_arb), 32'(8'b1000_0000));
        tick();
        chk("solo_regrant", 32'(gnt), 32'(8'b1000_0000));
        r = '0;
        tick();
        tick();
        // owner drops exactly at the limit
        r = 8'b0001_0000;
        for (int i = 0; i < MH; i++) tick();
        r = '0;
        tick();
        chk("drop_exp", 32'(expired), 32'd0);
        r = 8'b0001_0000;
        #1;
        chk("drop_mask", 32'(r_arb), 32'(8'b0001_0000));
        tick();
        chk("drop_regrant", 32'(gnt), 32'(8'b0001_0000));
        r = '0;
        tick();
        tick();
        // illegal arbiter output
        force_g = 1'b1;
        g_force = 8'b0000_0011;
        tick();
        chk("ill_err", 32'(err), 32'd1);
        chk("ill_gnt", 32'(gnt), 32'd0);
        force_g = 1'b0;
        tick();
        tick();
        chk("ill_sticky", 32'(err), 32'd1);
        // random traffic
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 2) == 0) r = 8'($urandom);
            rst = ($urandom_range(0, 59) == 0);
            force_g = ($urandom_range(0, 49) == 0);
            g_force = ($urandom_range(0, 1) == 0) ? bitv($urandom_range(0, N - 1)) : 8'($urandom);
            tick();
        end
        force_g = 1'b0;
        rst = 1'b1;
        tick();
        chk("final_err", 32'(err), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
